// File: rtl/processador_pwm_saida.sv
// Soft-ramping PWM driver for the 3-bit output PIO: maps level_in to a duty target
// and ramps the applied duty toward it in STEP increments, only at period boundaries.
module processador_pwm_saida #(
  parameter int PERIOD_BITS = 8,
  parameter int STEP        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             level_in,
  output logic                   pwm_out,
  output logic [PERIOD_BITS:0]   duty,
  output logic                   busy,
  output logic                   period_tick
);

  // Two spare bits let duty +/- STEP be formed without wrapping before clamping.
  localparam int              W       = PERIOD_BITS + 2;
  localparam logic [W-1:0]    FULL    = W'(1) << PERIOD_BITS;
  localparam logic [W-1:0]    STEP_W  = W'(STEP);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [PERIOD_BITS-1:0] cnt;
  logic [1:0]             state;
  logic                   boundary;
  logic [W-1:0]           target;
  logic [W-1:0]           duty_ext;
  logic [W-1:0]           duty_next;

  assign boundary    = (cnt == '1);
  assign period_tick = (cnt == '0);
  assign busy        = (state != ST_IDLE);
  assign duty_ext    = {1'b0, duty};

  always_comb begin
    // NOTE: default assignment first so no path leaves target unassigned (no latch).
    target = '0;
    if (level_in == 3'd7)
      target = FULL;
    else if (level_in != 3'd0)
      target = W'(level_in) << (PERIOD_BITS - 3);
  end

  // Clamp on the remaining distance so the step never overshoots the target.
  always_comb begin
    duty_next = duty_ext;
    if (duty_ext < target)
      duty_next = ((target - duty_ext) > STEP_W) ? duty_ext + STEP_W : target;
    else if (duty_ext > target)
      duty_next = ((duty_ext - target) > STEP_W) ? duty_ext - STEP_W : target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      duty    <= '0;
      state   <= ST_IDLE;
      pwm_out <= 1'b0;
    end else begin
      // NOTE: non-blocking so pwm_out compares against this cycle's cnt/duty, not the updated ones.
      cnt     <= cnt + 1'b1;
      pwm_out <= ({1'b0, cnt} < duty);
      if (boundary) begin
        duty <= duty_next[PERIOD_BITS:0];
        if (duty_next == target)
          state <= ST_IDLE;
        else if (duty_next < target)
          state <= ST_UP;
        else
          state <= ST_DOWN;
      end
    end
  end

endmodule

// File: tb/tb_processador_pwm_saida.sv
// Self-checking bench: two instances (STEP=2 and STEP=4, period 16) compared every
// cycle against a period-level reference model driven by random and directed levels.
module tb_processador_pwm_saida;

  localparam int PB  = 4;
  localparam int PER = 1 << PB;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] level0, level1;
  logic       pwm0, pwm1, busy0, busy1, tick0, tick1;
  logic [PB:0] duty0, duty1;

  int total = 0;
  int bad   = 0;

  int m_cnt  [2];
  int m_duty [2];
  int m_pwm  [2];
  int m_busy [2];
  int stp    [2] = '{2, 4};

  always #5 clk = ~clk;

  processador_pwm_saida #(.PERIOD_BITS(PB), .STEP(2)) u_dut0 (
    .clk(clk), .reset(reset), .level_in(level0),
    .pwm_out(pwm0), .duty(duty0), .busy(busy0), .period_tick(tick0)
  );

  processador_pwm_saida #(.PERIOD_BITS(PB), .STEP(4)) u_dut1 (
    .clk(clk), .reset(reset), .level_in(level1),
    .pwm_out(pwm1), .duty(duty1), .busy(busy1), .period_tick(tick1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int target_of(input int lvl);
    if (lvl == 0) return 0;
    if (lvl == 7) return PER;
    return lvl * (PER / 8);
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_duty[k] = 0; m_pwm[k] = 0; m_busy[k] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int lvl, t, nxt_pwm;
    if (reset) begin
      model_zero();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      lvl = (k == 0) ? int'(level0) : int'(level1);
      nxt_pwm = (m_cnt[k] < m_duty[k]) ? 1 : 0;
      if (m_cnt[k] == PER - 1) begin
        t = target_of(lvl);
        if (m_duty[k] < t)
          m_duty[k] = (m_duty[k] + stp[k] < t) ? m_duty[k] + stp[k] : t;
        else if (m_duty[k] > t)
          m_duty[k] = (m_duty[k] - stp[k] > t) ? m_duty[k] - stp[k] : t;
        m_busy[k] = (m_duty[k] != t) ? 1 : 0;
      end
      m_cnt[k] = (m_cnt[k] + 1) % PER;
      m_pwm[k] = nxt_pwm;
    end
  endtask

  task automatic check_outputs();
    check("duty0", 32'(duty0), m_duty[0]);
    check("pwm0",  32'(pwm0),  m_pwm[0]);
    check("busy0", 32'(busy0), m_busy[0]);
    check("tick0", 32'(tick0), (m_cnt[0] == 0) ? 1 : 0);
    check("duty1", 32'(duty1), m_duty[1]);
    check("pwm1",  32'(pwm1),  m_pwm[1]);
    check("busy1", 32'(busy1), m_busy[1]);
    check("tick1", 32'(tick1), (m_cnt[1] == 0) ? 1 : 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges and checks it acts at once.
  task automatic apply_reset(input logic [2:0] l0, input logic [2:0] l1);
    #2;
    reset = 1'b1;
    #1;
    model_zero();
    check_outputs();
    level0 = l0;
    level1 = l1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n, hi;
    reset  = 1'b1;
    level0 = 3'd0;
    level1 = 3'd0;
    #1;
    model_zero();
    check_outputs();
    #1;
    reset = 1'b0;

    // Level 0: output stays low, tick every period.
    for (int i = 0; i < 4 * PER; i++) cycle();
    check("lvl0_duty", 32'(duty0), 0);

    // Level 7 on dut0 (full ramp), level 3 on dut1 (STEP=4 clamp to 6).
    apply_reset(3'd7, 3'd3);
    for (int i = 0; i < 10 * PER; i++) cycle();
    check("full_duty0", 32'(duty0), PER);
    check("full_busy0", 32'(busy0), 0);
    check("clamp_duty1", 32'(duty1), 6);
    check("clamp_busy1", 32'(busy1), 0);
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      cycle();
      hi += int'(pwm0);
    end
    check("full_pwm_hi", 32'(hi), PER);

    // Steady level 3 on dut0: exactly 6 high cycles per period once settled.
    level0 = 3'd3;
    for (int i = 0; i < 8 * PER; i++) cycle();
    while (m_cnt[0] != 0) cycle();
    hi = 0;
    for (int i = 0; i < PER; i++) begin
      cycle();
      hi += int'(pwm0);
    end
    check("lvl3_pwm_hi", 32'(hi), 6);

    // Ramp up, reverse at duty 8; toggles between boundaries must be ignored.
    apply_reset(3'd7, 3'd7);
    n = 0;
    while (m_duty[0] != 8 && n < 20 * PER) begin
      cycle();
      n++;
    end
    check("reach_duty8", 32'(duty0), 8);
    for (int i = 0; i < 5 * PER; i++) begin
      level0 = (m_cnt[0] == PER - 1) ? 3'd1 : 3'(($urandom_range(0, 7)));
      cycle();
    end
    level0 = 3'd1;
    check("rev_duty0", 32'(duty0), 2);
    check("rev_busy0", 32'(busy0), 0);

    // Reset mid-ramp at duty 10, then ramp restarts from 0.
    apply_reset(3'd7, 3'd7);
    n = 0;
    while (m_duty[0] != 10 && n < 20 * PER) begin
      cycle();
      n++;
    end
    check("reach_duty10", 32'(duty0), 10);
    for (int i = 0; i < 3; i++) cycle();
    apply_reset(3'd7, 3'd7);
    check("mid_rst_duty0", 32'(duty0), 0);
    for (int i = 0; i < 3 * PER; i++) cycle();
    check("restart_duty0", 32'(duty0), 6);

    // Random level changes on both channels.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 19) == 0) level0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) level1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) apply_reset(level0, level1);
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/processador_pwm_saida.md
# processador_pwm_saida

Soft-ramping PWM driver sitting directly downstream of the 3-bit output PIO. It consumes the PIO's `out_port` as a brightness level (0–7), converts it to a duty cycle, and drives a single PWM pin (LED/actuator). Duty changes are applied only at PWM period boundaries and ramp in fixed steps toward the target, so software writes never produce glitches or abrupt jumps.

## Interface
Parameters:
- `PERIOD_BITS`, 8: PWM counter width; period = 2^PERIOD_BITS cycles; must be ≥ 3.
- `STEP`, 8: duty increment/decrement applied per period boundary while ramping; must be ≥ 1.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state immediately.
- `level_in`  in  3  brightness level, connected to the PIO `out_port`; same clock domain, no synchroniser.
- `pwm_out`  out  1  registered PWM output.
- `duty`  out  PERIOD_BITS+1  current applied duty, in counter ticks (0 … 2^PERIOD_BITS).
- `busy`  out  1  high while `duty` has not yet reached the target sampled at the last boundary.
- `period_tick`  out  1  one-cycle strobe, high in the cycle the counter equals 0.

## Operation
- Free-running counter `cnt` (PERIOD_BITS wide), increments every cycle, wraps from MAX = 2^PERIOD_BITS−1 to 0.
- Target mapping, combinational from `level_in`: level 0 → 0 (always off); levels 1–6 → `level << (PERIOD_BITS−3)`; level 7 → 2^PERIOD_BITS (always on).
- Boundary cycle = cycle with `cnt == MAX`. Only there:
  - `level_in` is sampled and the target is computed; values present on other cycles are ignored.
  - If `duty < target`: `duty <= min(duty+STEP, target)`.
  - If `duty > target`: `duty <= max(duty−STEP, target)`.
  - Equal: `duty` holds.
  - State register updated from the new duty vs. the sampled target: IDLE (equal), UP (new duty < target), DOWN (new duty > target). `busy = (state != IDLE)`.
- Step arithmetic uses PERIOD_BITS+2 bits internally; clamping guarantees no overshoot, underflow or wrap.
- Mid-ramp target change: direction is re-evaluated at every boundary; reversal costs no extra period.
- `pwm_out` register: next value = `(cnt < duty)`, evaluated with the current `cnt` and `duty`. `duty` = 0 → never high; `duty` = 2^PERIOD_BITS → always high.

## Timing
- Reset values (asynchronous): `cnt`=0, `duty`=0, state IDLE, `busy`=0, `pwm_out`=0, `period_tick` reflects `cnt`=0 and is therefore 1 during reset; the counter starts incrementing on the first edge after `reset` deasserts.
- `pwm_out` lags the counter by one cycle: high in cycle t+1 iff `cnt(t) < duty(t)`; each period's high pulse is contiguous and starts one cycle after `period_tick`.
- New duty is visible on `duty` in the cycle where `cnt` = 0, and it governs that whole period.
- Latency from a `level_in` change to the first duty movement: up to 2^PERIOD_BITS cycles (the next boundary).
- Full ramp 0 → 2^PERIOD_BITS takes ceil(2^PERIOD_BITS / STEP) boundaries.
- `busy` changes only at boundaries, together with `duty`.
- Reset asserted mid-ramp: everything returns to reset values immediately; ramping after release restarts from `duty`=0.

## Test plan
All scenarios use PERIOD_BITS=4, STEP=2 (period 16) unless stated.
- Reset with `level_in`=0, run 4 periods -> `pwm_out`=0 throughout, `duty`=0, `busy`=0, `period_tick` every 16 cycles.
- `level_in`=7 from reset -> `duty` goes 2,4,…,16 over 8 boundaries; `busy`=1 until `duty`=16, then 0; `pwm_out` is then constantly 1.
- Steady `level_in`=3 (target 6), after settling -> `pwm_out` high exactly 6 consecutive cycles per period, starting one cycle after `period_tick`.
- Ramp toward 7; at `duty`=8, set `level_in`=1 (target 2) -> `duty` goes 6,4,2 on successive boundaries; `busy` drops when `duty`=2. Toggle `level_in` between boundaries -> no effect.
- STEP=4, `level_in`=3 from reset -> `duty` goes 4, then 6 (clamped, no overshoot), then holds; `busy` falls at the second boundary.
- Assert `reset` asynchronously at `duty`=10 mid-ramp -> `pwm_out`, `duty`, `busy` go to 0 immediately; after release with `level_in`=7, the ramp restarts 2,4,….
